// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, LSU state type and
// the request legality check used when a request is accepted.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_t;

  // True when funct3 is legal for the operation and the address is aligned.
  function automatic logic req_ok(input logic is_store, input logic [2:0] f3,
                                  input logic [1:0] addr_lo);
    logic legal;
    logic aligned;
    legal   = 1'b0;
    aligned = 1'b0;
    case (f3)
      F3_B:  begin legal = 1'b1;      aligned = 1'b1;              end
      F3_H:  begin legal = 1'b1;      aligned = ~addr_lo[0];       end
      F3_W:  begin legal = 1'b1;      aligned = (addr_lo == 2'b00); end
      F3_BU: begin legal = ~is_store; aligned = 1'b1;              end
      F3_HU: begin legal = ~is_store; aligned = ~addr_lo[0];       end
      default: ;
    endcase
    return legal & aligned;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory request/response bus between the LSU (master) and memory (slave).
// mem_req is the request valid; fields are stable while it is high, and a
// transfer completes on any rising edge where mem_req and mem_ack are both 1.
interface lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane select plus sign/zero extension for
// loads. Purely combinational; the store path and load path are independent.
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  i_st_funct3,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_store_data,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_load_data
);

  logic [31:0] w_lane;

  always_comb begin
    o_wdata = i_store_data;
    o_wstrb = 4'b1111;
    case (i_st_funct3)
      F3_B: begin
        o_wdata = {4{i_store_data[7:0]}};
        o_wstrb = 4'b0001 << i_st_addr_lo;
      end
      F3_H: begin
        o_wdata = {2{i_store_data[15:0]}};
        o_wstrb = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Bring the addressed byte/halfword down to bit 0 before extension.
  assign w_lane = i_rdata >> {i_ld_addr_lo, 3'b000};

  always_comb begin
    o_load_data = w_lane;
    case (i_ld_funct3)
      F3_B:  o_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
      F3_H:  o_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
      F3_BU: o_load_data = {24'h0, w_lane[7:0]};
      F3_HU: o_load_data = {16'h0, w_lane[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request from execute, checks it, issues a single
// data-memory access, and reports completion, fault or timeout with a done pulse.
module lsu
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  lsu_if.master       mem,
  output lsu_state_t  dbg_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t  r_state;
  lsu_state_t  w_next_state;
  logic [CW-1:0] r_cnt;
  logic        r_fault;
  logic        r_is_load;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [2:0]  r_ld_funct3;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_load_data;

  logic        w_start_valid;
  logic        w_start_fault;
  logic        w_issue;
  logic        w_capture;
  logic        w_set_fault;
  logic        w_cnt_inc;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [31:0] w_load_ext;

  // A start with neither op bit set is not a request at all; anything else
  // that fails the legality check completes immediately as a fault.
  assign w_start_valid = start && (is_load ^ is_store) && req_ok(is_store, funct3, addr[1:0]);
  assign w_start_fault = start && (is_load || is_store) && !w_start_valid;

  lsu_align u_align (
    .i_st_funct3  (funct3),
    .i_st_addr_lo (addr[1:0]),
    .i_store_data (store_data),
    .o_wdata      (w_wdata),
    .o_wstrb      (w_wstrb),
    .i_ld_funct3  (r_ld_funct3),
    .i_ld_addr_lo (r_addr_lo),
    .i_rdata      (mem.mem_rdata),
    .o_load_data  (w_load_ext)
  );

  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_capture    = 1'b0;
    w_set_fault  = 1'b0;
    w_cnt_inc    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_valid) begin
          w_next_state = ST_ACCESS;
          w_issue      = 1'b1;
          busy         = 1'b1;
        end else if (w_start_fault) begin
          w_next_state = ST_DONE;
          w_set_fault  = 1'b1;
          busy         = 1'b1;
        end
      end
      ST_ACCESS: begin
        busy = 1'b1;
        // An ack in the last allowed cycle still wins over the timeout.
        if (mem.mem_ack) begin
          w_next_state = ST_DONE;
          w_capture    = r_is_load;
        end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          w_next_state = ST_DONE;
          w_set_fault  = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_fault     <= 1'b0;
      r_is_load   <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_wstrb     <= 4'b0000;
      r_ld_funct3 <= 3'b000;
      r_addr_lo   <= 2'b00;
      r_load_data <= 32'h0;
    end else begin
      r_state <= w_next_state;
      r_fault <= w_set_fault;
      if (w_issue) begin
        r_cnt       <= '0;
        r_is_load   <= is_load;
        r_we        <= is_store;
        r_addr      <= {addr[31:2], 2'b00};
        r_wdata     <= is_store ? w_wdata : 32'h0;
        r_wstrb     <= is_store ? w_wstrb : 4'b0000;
        r_ld_funct3 <= funct3;
        r_addr_lo   <= addr[1:0];
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_capture) begin
        r_load_data <= w_load_ext;
      end
    end
  end

  assign mem.mem_req   = (r_state == ST_ACCESS);
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;
  assign mem.mem_wstrb = r_wstrb;

  assign done      = (r_state == ST_DONE);
  assign fault     = r_fault;
  assign load_data = r_load_data;
  assign dbg_state = r_state;

endmodule
